// File: rtl/mem_l2a.sv
// L2 memory router: CPU L1 bus to DDR (behind a 64-line direct-mapped write-through read cache) and MMIO.
// Optional MMIO response timeout is compiled in with `define MEM_L2A_MMIO_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_l2a #(
    parameter int CACHE_IDX_BITS = 6,
    parameter int MMIO_TIMEOUT   = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  memAddr,
    input  logic [4:0]   memOpm,
    input  logic [127:0] memOutData,
    output logic [127:0] memInData,
    output logic [1:0]   memOK,
    output logic [31:0]  ddrMemAddr,
    output logic [4:0]   ddrMemOpm,
    output logic [127:0] ddrMemDataOut,
    input  logic [127:0] ddrMemDataIn,
    input  logic [1:0]   ddrMemOK,
    output logic [31:0]  mmioAddr,
    output logic [4:0]   mmioOpm,
    input  logic [63:0]  mmioInData,
    output logic [63:0]  mmioOutDataQ,
    input  logic [1:0]   mmioOK,
    output logic [2:0]   stateDbg
);
    // Every bus uses the same 2-bit status handshake: a requester holds its opcode
    // non-zero until the responder shows OK or FAULT, then drops it to 0 and waits
    // for the responder to return to READY before the transfer counts as closed.
    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_OK    = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [4:0] DDR_LOAD  = 5'h0F;
    localparam logic [4:0] DDR_STORE = 5'h17;

    localparam int LINES = 1 << CACHE_IDX_BITS;
    localparam int TAG_W = 28 - CACHE_IDX_BITS;

    typedef enum logic [2:0] {
        IDLE, CHK, DDR_REQ, DDR_REL, MMIO_REQ, MMIO_REL, DONE
    } stateT;

    stateT state;

    logic [27:0]  lineAddrQ;
    logic [127:0] dataQ;
    logic         isStoreQ;
    logic         hitQ;
    logic         faultQ;

    logic [127:0]      lineMem [LINES];
    logic [TAG_W-1:0]  tagMem  [LINES];
    logic [LINES-1:0]  lineValid;

    logic [CACHE_IDX_BITS-1:0] lineIdx;
    logic [TAG_W-1:0]          lineTag;
    logic                      hit;
    logic                      fillEn;
    logic [127:0]              fillData;

`ifdef MEM_L2A_MMIO_TIMEOUT_EN
    localparam int TO_W = $clog2(MMIO_TIMEOUT + 1);
    logic [TO_W-1:0] toCnt;
`endif

    assign stateDbg = state;

    always_comb begin
        lineIdx  = lineAddrQ[CACHE_IDX_BITS-1:0];
        lineTag  = lineAddrQ[27:CACHE_IDX_BITS];
        hit      = lineValid[lineIdx] && (tagMem[lineIdx] == lineTag);
        // Loads allocate; stores only refresh a line that is already resident.
        fillEn   = (state == DDR_REQ) && (ddrMemOK == ST_OK) && (!isStoreQ || hitQ);
        fillData = isStoreQ ? dataQ : ddrMemDataIn;
    end

    always_ff @(posedge clock) begin
        if (reset && fillEn) begin
            lineMem[lineIdx] <= fillData;
            tagMem[lineIdx]  <= lineTag;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            lineValid     <= '0;
            memOK         <= ST_READY;
            memInData     <= '0;
            ddrMemAddr    <= '0;
            ddrMemOpm     <= '0;
            ddrMemDataOut <= '0;
            mmioAddr      <= '0;
            mmioOpm       <= '0;
            mmioOutDataQ  <= '0;
            lineAddrQ     <= '0;
            dataQ         <= '0;
            isStoreQ      <= 1'b0;
            hitQ          <= 1'b0;
            faultQ        <= 1'b0;
`ifdef MEM_L2A_MMIO_TIMEOUT_EN
            toCnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    memOK  <= ST_READY;
                    faultQ <= 1'b0;
`ifdef MEM_L2A_MMIO_TIMEOUT_EN
                    toCnt  <= '0;
`endif
                    if (memOpm != 5'd0) begin
                        lineAddrQ <= memAddr[31:4];
                        dataQ     <= memOutData;
                        isStoreQ  <= memOpm[4];
                        memOK     <= ST_HOLD;
                        if (memAddr[31:28] == 4'hF) begin
                            mmioAddr     <= memAddr;
                            mmioOpm      <= memOpm;
                            mmioOutDataQ <= memOutData[63:0];
                            state        <= MMIO_REQ;
                        end else begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (!isStoreQ && hit) begin
                        memInData <= lineMem[lineIdx];
                        memOK     <= ST_OK;
                        state     <= DONE;
                    end else begin
                        ddrMemAddr <= {lineAddrQ, 4'h0};
                        ddrMemOpm  <= isStoreQ ? DDR_STORE : DDR_LOAD;
                        if (isStoreQ) ddrMemDataOut <= dataQ;
                        hitQ       <= hit;
                        state      <= DDR_REQ;
                    end
                end
                DDR_REQ: begin
                    if (ddrMemOK == ST_OK) begin
                        if (!isStoreQ) begin
                            memInData          <= ddrMemDataIn;
                            lineValid[lineIdx] <= 1'b1;
                        end
                        ddrMemOpm <= '0;
                        state     <= DDR_REL;
                    end else if (ddrMemOK == ST_FAULT) begin
                        faultQ    <= 1'b1;
                        ddrMemOpm <= '0;
                        state     <= DDR_REL;
                    end
                end
                DDR_REL: begin
                    if (ddrMemOK == ST_READY) begin
                        memOK <= faultQ ? ST_FAULT : ST_OK;
                        state <= DONE;
                    end
                end
                MMIO_REQ: begin
                    if (mmioOK == ST_OK || mmioOK == ST_FAULT) begin
                        memInData <= {64'h0, mmioInData};
                        faultQ    <= (mmioOK == ST_FAULT);
                        mmioOpm   <= '0;
                        state     <= MMIO_REL;
                    end
`ifdef MEM_L2A_MMIO_TIMEOUT_EN
                    else if (mmioOK == ST_READY) begin
                        if (toCnt == TO_W'(MMIO_TIMEOUT - 1)) begin
                            memInData <= '0;
                            faultQ    <= 1'b1;
                            mmioOpm   <= '0;
                            state     <= MMIO_REL;
                        end else begin
                            toCnt <= toCnt + 1'b1;
                        end
                    end
`endif
                end
                MMIO_REL: begin
                    if (mmioOK == ST_READY) begin
                        memOK <= faultQ ? ST_FAULT : ST_OK;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (memOpm == 5'd0) begin
                        memOK <= ST_READY;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_l2a.sv
// Scoreboard bench for mem_l2a: directed CPU requests, DDR/MMIO responder models, response monitor.
`timescale 1ns/1ps
module tb_mem_l2a;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  memAddr;
    logic [4:0]   memOpm;
    logic [127:0] memOutData;
    logic [127:0] memInData;
    logic [1:0]   memOK;
    logic [31:0]  ddrMemAddr;
    logic [4:0]   ddrMemOpm;
    logic [127:0] ddrMemDataOut;
    logic [127:0] ddrMemDataIn;
    logic [1:0]   ddrMemOK;
    logic [31:0]  mmioAddr;
    logic [4:0]   mmioOpm;
    logic [63:0]  mmioInData;
    logic [63:0]  mmioOutDataQ;
    logic [1:0]   mmioOK;
    logic [2:0]   stateDbg;

    always #5 clock = ~clock;

    mem_l2a dut (
        .clock(clock), .reset(reset),
        .memAddr(memAddr), .memOpm(memOpm), .memOutData(memOutData),
        .memInData(memInData), .memOK(memOK),
        .ddrMemAddr(ddrMemAddr), .ddrMemOpm(ddrMemOpm), .ddrMemDataOut(ddrMemDataOut),
        .ddrMemDataIn(ddrMemDataIn), .ddrMemOK(ddrMemOK),
        .mmioAddr(mmioAddr), .mmioOpm(mmioOpm), .mmioInData(mmioInData),
        .mmioOutDataQ(mmioOutDataQ), .mmioOK(mmioOK), .stateDbg(stateDbg)
    );

    int checks = 0;
    int errors = 0;

    // {memOK, memInData}
    logic [129:0] exp_q[$];
    // {check_data, opm, addr, data}
    logic [165:0] ddr_q[$];
    logic [101:0] mmio_q[$];

    logic [127:0] ddr_rd_data = '0;
    bit           ddr_fault   = 1'b0;
    logic [63:0]  mmio_rd_data = '0;
    bit           mmio_fault  = 1'b0;
    bit           mmio_hang   = 1'b0;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DA = {16{8'hAA}};
    localparam logic [127:0] D2 = 128'h5555666677778888999900001111CAFE;
    localparam logic [127:0] D3 = 128'h3333333344444444BEEFBEEF00000003;
    localparam logic [127:0] D4 = 128'h4444000044440000DDDD0000EEEE0004;
    localparam logic [127:0] D5 = {16{8'h55}};

    task automatic chk(input string name, input logic [165:0] act, input logic [165:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: pops on every transition of memOK into OK or FAULT.
    initial begin
        logic [1:0]   prev;
        logic [129:0] e;
        prev = 2'd0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && (memOK == 2'd1 || memOK == 2'd3) && !(prev == 2'd1 || prev == 2'd3)) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_response: got %0h with nothing expected", {memOK, memInData});
                end else begin
                    e = exp_q.pop_front();
                    chk("response", {36'h0, memOK, memInData}, {36'h0, e});
                end
            end
            prev = memOK;
        end
    end

    // DDR responder: answers after 5 cycles, then returns to READY once opm drops.
    initial begin
        logic [165:0] e;
        ddrMemOK = 2'd0;
        ddrMemDataIn = '0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && ddrMemOpm != 5'd0) begin
                if (ddr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ddr_req: got opm %0h addr %0h, expected no request", ddrMemOpm, ddrMemAddr);
                    e = {1'b0, ddrMemOpm, ddrMemAddr, 128'h0};
                end else begin
                    e = ddr_q.pop_front();
                    if (e[165]) chk("ddr_req", {1'b0, ddrMemOpm, ddrMemAddr, ddrMemDataOut}, {1'b0, e[164:0]});
                    else        chk("ddr_req", {129'h0, ddrMemOpm, ddrMemAddr}, {129'h0, e[164:128]});
                end
                repeat (5) @(negedge clock);
                chk("ddr_req_held", {129'h0, ddrMemOpm, ddrMemAddr}, {129'h0, e[164:128]});
                ddrMemDataIn = ddr_rd_data;
                ddrMemOK = ddr_fault ? 2'd3 : 2'd1;
                while (ddrMemOpm != 5'd0) @(negedge clock);
                ddrMemOK = 2'd0;
            end
        end
    end

    // MMIO responder: answers after 3 cycles unless told to hang.
    initial begin
        logic [101:0] e;
        mmioOK = 2'd0;
        mmioInData = '0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && mmioOpm != 5'd0) begin
                if (mmio_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mmio_req: got opm %0h addr %0h, expected no request", mmioOpm, mmioAddr);
                end else begin
                    e = mmio_q.pop_front();
                    if (e[101]) chk("mmio_req", {65'h0, mmioOpm, mmioAddr, mmioOutDataQ}, {65'h0, e[100:0]});
                    else        chk("mmio_req", {129'h0, mmioOpm, mmioAddr}, {129'h0, e[100:64]});
                end
                if (!mmio_hang) begin
                    repeat (3) @(negedge clock);
                    mmioInData = mmio_rd_data;
                    mmioOK = mmio_fault ? 2'd3 : 2'd1;
                end
                while (mmioOpm != 5'd0) @(negedge clock);
                mmioOK = 2'd0;
            end
        end
    end

    // Issue one request, scramble the inputs once latched, wait for completion, then release.
    task automatic do_req(input logic [31:0] a, input logic [4:0] op, input logic [127:0] d,
                          input int budget, output int lat);
        @(negedge clock);
        memAddr = a; memOpm = op; memOutData = d;
        lat = 1;
        @(posedge clock); #1;
        memAddr = $urandom;
        memOutData = {$urandom, $urandom, $urandom, $urandom};
        memOpm = 5'h01;
        while (lat < budget && !(memOK == 2'd1 || memOK == 2'd3)) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!(memOK == 2'd1 || memOK == 2'd3)) begin
            checks++; errors++;
            $display("FAIL req_timeout: got memOK %0d after %0d cycles, expected OK or FAULT", memOK, lat);
        end
        @(negedge clock);
        memOpm = 5'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (memOK == 2'd0) break;
        end
        chk("release_ready", {164'h0, memOK}, 166'h0);
    endtask

    initial begin
        int lat;
        reset = 1'b0;
        memAddr = '0; memOpm = '0; memOutData = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_memOK", {164'h0, memOK}, 166'h0);
        chk("rst_memInData", {38'h0, memInData}, 166'h0);
        chk("rst_ddr", {1'b0, ddrMemOpm, ddrMemAddr, ddrMemDataOut}, 166'h0);
        chk("rst_mmio", {65'h0, mmioOpm, mmioAddr, mmioOutDataQ}, 166'h0);
        @(negedge clock);
        reset = 1'b1;

        // Cold load miss, then hit.
        ddr_rd_data = D1;
        ddr_q.push_back({1'b0, 5'h0F, 32'h0000_1000, 128'h0});
        exp_q.push_back({2'd1, D1});
        do_req(32'h0000_1000, 5'h0B, '0, 200, lat);
        exp_q.push_back({2'd1, D1});
        do_req(32'h0000_1000, 5'h0B, '0, 200, lat);
        chk("hit_latency", 166'(lat), 166'd2);

        // Store hit writes through and updates the line; load data output held.
        ddr_q.push_back({1'b1, 5'h17, 32'h0000_1000, DA});
        exp_q.push_back({2'd1, D1});
        do_req(32'h0000_1008, 5'h14, DA, 200, lat);
        exp_q.push_back({2'd1, DA});
        do_req(32'h0000_1000, 5'h0B, '0, 200, lat);
        chk("store_hit_latency", 166'(lat), 166'd2);

        // Conflict on index 0: each load evicts the other.
        ddr_rd_data = D2;
        ddr_q.push_back({1'b0, 5'h0F, 32'h0000_1400, 128'h0});
        exp_q.push_back({2'd1, D2});
        do_req(32'h0000_1400, 5'h0B, '0, 200, lat);
        ddr_rd_data = DA;
        ddr_q.push_back({1'b0, 5'h0F, 32'h0000_1000, 128'h0});
        exp_q.push_back({2'd1, DA});
        do_req(32'h0000_100C, 5'h0B, '0, 200, lat);
        ddr_rd_data = D2;
        ddr_q.push_back({1'b0, 5'h0F, 32'h0000_1400, 128'h0});
        exp_q.push_back({2'd1, D2});
        do_req(32'h0000_1400, 5'h0B, '0, 200, lat);

        // MMIO load and store; never cached.
        mmio_rd_data = 64'h1234_5678;
        mmio_q.push_back({1'b0, 5'h0A, 32'hF000_E030, 64'h0});
        exp_q.push_back({2'd1, 96'h0, 32'h1234_5678});
        do_req(32'hF000_E030, 5'h0A, '0, 200, lat);
        mmio_rd_data = 64'h0BAD;
        mmio_q.push_back({1'b1, 5'h13, 32'hF000_0010, 64'hDEAD_BEEF_CAFE_F00D});
        exp_q.push_back({2'd1, 64'h0, 64'h0BAD});
        do_req(32'hF000_0010, 5'h13, {64'h1111, 64'hDEAD_BEEF_CAFE_F00D}, 200, lat);
        mmio_rd_data = 64'h77;
        mmio_q.push_back({1'b0, 5'h0A, 32'hF000_E030, 64'h0});
        exp_q.push_back({2'd1, 64'h0, 64'h77});
        do_req(32'hF000_E030, 5'h0A, '0, 200, lat);

        // DDR fault: no fill, data held, next load misses again.
        ddr_fault = 1'b1;
        ddr_rd_data = D4;
        ddr_q.push_back({1'b0, 5'h0F, 32'h0000_2000, 128'h0});
        exp_q.push_back({2'd3, 64'h0, 64'h77});
        do_req(32'h0000_2000, 5'h0B, '0, 200, lat);
        ddr_fault = 1'b0;
        ddr_rd_data = D3;
        ddr_q.push_back({1'b0, 5'h0F, 32'h0000_2000, 128'h0});
        exp_q.push_back({2'd1, D3});
        do_req(32'h0000_2000, 5'h0B, '0, 200, lat);

        // Store miss does not allocate.
        ddr_q.push_back({1'b1, 5'h17, 32'h0000_3000, D5});
        exp_q.push_back({2'd1, D3});
        do_req(32'h0000_3000, 5'h14, D5, 200, lat);
        ddr_rd_data = D4;
        ddr_q.push_back({1'b0, 5'h0F, 32'h0000_3000, 128'h0});
        exp_q.push_back({2'd1, D4});
        do_req(32'h0000_3000, 5'h0B, '0, 200, lat);

        // MMIO fault reports FAULT with the returned data.
        mmio_fault = 1'b1;
        mmio_rd_data = 64'hFA17;
        mmio_q.push_back({1'b0, 5'h0B, 32'hF000_0020, 64'h0});
        exp_q.push_back({2'd3, 64'h0, 64'hFA17});
        do_req(32'hF000_0020, 5'h0B, '0, 200, lat);
        mmio_fault = 1'b0;

        // Silent MMIO device.
        mmio_hang = 1'b1;
        mmio_q.push_back({1'b0, 5'h0A, 32'hF000_0040, 64'h0});
`ifdef MEM_L2A_MMIO_TIMEOUT_EN
        exp_q.push_back({2'd3, 128'h0});
        do_req(32'hF000_0040, 5'h0A, '0, 2000, lat);
        chk("timeout_window", 166'(lat >= 256 && lat <= 260), 166'd1);
        mmio_hang = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_reset_memOK", {164'h0, memOK}, 166'h0);
        @(negedge clock);
        reset = 1'b1;
`else
        @(negedge clock);
        memAddr = 32'hF000_0040; memOpm = 5'h0A; memOutData = '0;
        repeat (300) @(posedge clock);
        #1;
        chk("hang_hold", {164'h0, memOK}, {164'h0, 2'd2});
        chk("hang_mmioOpm", {161'h0, mmioOpm}, {161'h0, 5'h0A});
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("midreset_mmioOpm", {161'h0, mmioOpm}, 166'h0);
        chk("midreset_memOK", {164'h0, memOK}, 166'h0);
        chk("midreset_mmioAddr", {134'h0, mmioAddr}, 166'h0);
        @(negedge clock);
        reset = 1'b1;
        memOpm = 5'd0;
        mmio_hang = 1'b0;
`endif
        repeat (2) @(posedge clock);

        // Reset cleared the valid bits: a previously resident line misses.
        ddr_rd_data = D2;
        ddr_q.push_back({1'b0, 5'h0F, 32'h0000_1400, 128'h0});
        exp_q.push_back({2'd1, D2});
        do_req(32'h0000_1400, 5'h0B, '0, 200, lat);

        repeat (4) @(posedge clock);
        chk("exp_q_drained", 166'(exp_q.size()), 166'd0);
        chk("ddr_q_drained", 166'(ddr_q.size()), 166'd0);
        chk("mmio_q_drained", 166'(mmio_q.size()), 166'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
